// File: rtl/cpu_bus_master_if.sv
// CPU-side bus bundle: command queue input, CPU bus pins and read response.
// The master modport is the bus master's view; slave is the stimulus/peripheral side.
interface cpu_bus_master_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_wr;
    logic          cmd_r7;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [AW-1:0] bus_a;
    logic [DW-1:0] bus_d;
    logic          bus_d_oe;
    logic [DW-1:0] bus_d_in;
    logic          raw_wr;
    logic          raw_rd;
    logic          r7;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          busy;

    modport master (
        input  cmd_valid, cmd_wr, cmd_r7, cmd_addr, cmd_data, bus_d_in,
        output cmd_ready, bus_a, bus_d, bus_d_oe, raw_wr, raw_rd, r7,
               rsp_valid, rsp_data, busy
    );

    modport slave (
        output cmd_valid, cmd_wr, cmd_r7, cmd_addr, cmd_data, bus_d_in,
        input  cmd_ready, bus_a, bus_d, bus_d_oe, raw_wr, raw_rd, r7,
               rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/cpu_bus_master.sv
// Queued CPU bus master: runs commands as SETUP/STROBE/HOLD transactions.
// Define CPU_BUS_MASTER_READBACK_EN to build the read capture / response path.
module cpu_bus_master #(
    parameter int AW     = 16,
    parameter int DW     = 8,
    parameter int DEPTH  = 4,
    parameter int SETUP  = 1,
    parameter int STROBE = 2,
    parameter int HOLD   = 1
) (
    input  logic               clk,
    input  logic               nrst,
    cpu_bus_master_if.master   cb
);
    localparam int PW   = $clog2(DEPTH);
    localparam int MAXP = (SETUP > STROBE) ? ((SETUP > HOLD) ? SETUP : HOLD)
                                           : ((STROBE > HOLD) ? STROBE : HOLD);
    localparam int CW   = $clog2(MAXP + 1);

    typedef struct packed {
        logic          wr;
        logic          r7;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } cmd_t;

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;

    state_t        state, state_d;
    logic [CW-1:0] cnt, cnt_d;
    logic [PW:0]   wptr, rptr;
    cmd_t          mem [DEPTH];
    cmd_t          cur, nxt;
    logic          full, empty, push, pop, act;

    logic [AW-1:0] bus_a_q, bus_a_d;
    logic [DW-1:0] bus_d_q, bus_d_d;
    logic          oe_q, oe_d, wr_q, wr_d, rd_q, rd_d, r7_q, r7_d;

    assign full  = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
    assign empty = (wptr == rptr);
    assign push  = cb.cmd_valid && !full;

    always_ff @(posedge clk) begin
        if (push) mem[wptr[PW-1:0]] <= '{cb.cmd_wr, cb.cmd_r7, cb.cmd_addr, cb.cmd_data};
    end

    // Phase counter is loaded with len-1 on entry and the state exits at zero.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        pop     = 1'b0;
        case (state)
            ST_IDLE: if (!empty) begin
                pop     = 1'b1;
                state_d = ST_SETUP;
                cnt_d   = CW'(SETUP - 1);
            end
            ST_SETUP: if (cnt == '0) begin
                state_d = ST_STROBE;
                cnt_d   = CW'(STROBE - 1);
            end else cnt_d = cnt - CW'(1);
            ST_STROBE: if (cnt == '0) begin
                state_d = ST_HOLD;
                cnt_d   = CW'(HOLD - 1);
            end else cnt_d = cnt - CW'(1);
            ST_HOLD: if (cnt == '0) begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = ST_SETUP;
                    cnt_d   = CW'(SETUP - 1);
                end else state_d = ST_IDLE;
            end else cnt_d = cnt - CW'(1);
            default: state_d = ST_IDLE;
        endcase

        nxt     = pop ? mem[rptr[PW-1:0]] : cur;
        act     = (state_d != ST_IDLE);
        bus_a_d = act ? nxt.addr : bus_a_q;
        r7_d    = act ? nxt.r7 : r7_q;
        oe_d    = act && nxt.wr;
        bus_d_d = oe_d ? nxt.data : '0;
        wr_d    = (state_d == ST_STROBE) && nxt.wr;
        rd_d    = (state_d == ST_STROBE) && !nxt.wr;
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            wptr    <= '0;
            rptr    <= '0;
            cur     <= '0;
            bus_a_q <= '0;
            bus_d_q <= '0;
            oe_q    <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            r7_q    <= 1'b0;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            cur     <= nxt;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            bus_a_q <= bus_a_d;
            bus_d_q <= bus_d_d;
            oe_q    <= oe_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            r7_q    <= r7_d;
        end
    end

    assign cb.cmd_ready = !full;
    assign cb.busy      = (state != ST_IDLE) || !empty;
    assign cb.bus_a     = bus_a_q;
    assign cb.bus_d     = bus_d_q;
    assign cb.bus_d_oe  = oe_q;
    assign cb.raw_wr    = wr_q;
    assign cb.raw_rd    = rd_q;
    assign cb.r7        = r7_q;

`ifdef CPU_BUS_MASTER_READBACK_EN
    logic          rsp_valid_q;
    logic [DW-1:0] rsp_data_q;

    // Capture on the edge that ends the last strobe cycle; pulse lands in first HOLD cycle.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= (state == ST_STROBE) && (cnt == '0) && !cur.wr;
            if ((state == ST_STROBE) && (cnt == '0) && !cur.wr) rsp_data_q <= cb.bus_d_in;
        end
    end

    assign cb.rsp_valid = rsp_valid_q;
    assign cb.rsp_data  = rsp_data_q;
`else
    logic unused_bus_d_in;
    assign unused_bus_d_in = ^cb.bus_d_in;
    assign cb.rsp_valid    = 1'b0;
    assign cb.rsp_data     = '0;
`endif
endmodule
